// File: rtl/cache_pmem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I- and D-cache.
// One whole line transaction is granted at a time; responses go to the owner only.
module cache_pmem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 256,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              err_timeout
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     cnt_inc;
   logic              err_q, err_d;
   logic              i_req, d_req, pick_i;

   assign i_req   = i_read;
   assign d_req   = d_read | d_write;
   // I wins a tie only when D had the previous tie-break
   assign pick_i  = i_req & (~d_req | last_d_q);
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (i_req | d_req) begin
               cnt_d = '0;
               if (i_req & d_req) last_d_d = ~pick_i;
               if (pick_i) begin
                  state_d = SERVE_I;
                  rd_d    = 1'b1;
                  wr_d    = 1'b0;
                  addr_d  = i_address;
               end else begin
                  state_d = SERVE_D;
                  rd_d    = ~d_write;
                  wr_d    = d_write;
                  addr_d  = d_address;
                  wdata_d = d_wdata;
               end
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) begin
               state_d = IDLE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end else if (cnt_q != TO) begin
               // saturates at TO; TIMEOUT=0 never leaves zero
               cnt_d = cnt_inc;
               err_d = err_q | (cnt_inc == TO);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign pmem_read    = rd_q;
   assign pmem_write   = wr_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign err_timeout  = err_q;
   assign i_rdata      = pmem_rdata;
   assign d_rdata      = pmem_rdata;
   assign i_resp       = (state_q == SERVE_I) & pmem_resp & ~rst;
   assign d_resp       = (state_q == SERVE_D) & pmem_resp & ~rst;

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Bench for cache_pmem_arbiter: directed line transactions, then random
// traffic checked every cycle against a transaction-level model.
module tb_cache_pmem_arbiter;

   localparam int TMO = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read;
   logic [31:0]  i_address;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic         d_read, d_write;
   logic [31:0]  d_address;
   logic [255:0] d_wdata;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic         err_timeout;

   int checks = 0;
   int errors = 0;

   // model: owner 0=none 1=I 2=D
   int           m_owner = 0;
   logic         m_wr = 1'b0;
   logic         m_last_d = 1'b1;
   logic         m_err = 1'b0;
   logic [31:0]  m_addr = '0;
   logic [255:0] m_wdata = '0;
   int           m_wait = 0;
   bit           chk_en = 1'b0;
   bit           ev_i_done = 1'b0;
   bit           ev_d_done = 1'b0;
   logic         e_rd, e_wr, e_ir, e_dr, ir, dr, gi;

   always #5 clk = ~clk;

   cache_pmem_arbiter #(
      .ADDR_W(32), .LINE_W(256), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address),
      .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write),
      .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .err_timeout(err_timeout)
   );

   task automatic chk1(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
      end
   endtask

   task automatic chka(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // per-cycle compare, then advance the model with this cycle's inputs
   always @(negedge clk) begin
      if (chk_en) begin
         e_rd = (m_owner != 0) && !m_wr;
         e_wr = (m_owner != 0) && m_wr;
         e_ir = (m_owner == 1) && pmem_resp && !rst;
         e_dr = (m_owner == 2) && pmem_resp && !rst;
         chk1("m_pmem_read", pmem_read, e_rd);
         chk1("m_pmem_write", pmem_write, e_wr);
         chk1("m_i_resp", i_resp, e_ir);
         chk1("m_d_resp", d_resp, e_dr);
         chk1("m_err", err_timeout, m_err);
         chkw("m_i_rdata", i_rdata, pmem_rdata);
         chkw("m_d_rdata", d_rdata, pmem_rdata);
         if (m_owner != 0) chka("m_addr", pmem_address, m_addr);
         if (e_wr) chkw("m_wdata", pmem_wdata, m_wdata);
         if (e_ir) ev_i_done = 1'b1;
         if (e_dr) ev_d_done = 1'b1;
         if (rst) begin
            m_owner = 0; m_wr = 1'b0; m_last_d = 1'b1; m_err = 1'b0;
            m_addr = '0; m_wdata = '0; m_wait = 0;
         end else if (m_owner == 0) begin
            ir = i_read;
            dr = d_read | d_write;
            if (ir && dr) begin
               gi = m_last_d;
               m_last_d = !gi;
            end else begin
               gi = ir;
            end
            if (ir || dr) begin
               m_owner = gi ? 1 : 2;
               m_wr    = gi ? 1'b0 : d_write;
               m_addr  = gi ? i_address : d_address;
               if (!gi) m_wdata = d_wdata;
               m_wait  = 0;
            end
         end else if (pmem_resp) begin
            m_owner = 0;
         end else begin
            m_wait++;
            if (TMO != 0 && m_wait == TMO) m_err = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; i_read = 0; i_address = '0;
      d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
      pmem_rdata = '0; pmem_resp = 0;
      tick();
      chk_en = 1'b1;
      neg();
      chk1("rst_pmem_read", pmem_read, 1'b0);
      chk1("rst_pmem_write", pmem_write, 1'b0);
      chka("rst_addr", pmem_address, 32'h0);
      chkw("rst_wdata", pmem_wdata, '0);
      chk1("rst_err", err_timeout, 1'b0);
      chk1("rst_i_resp", i_resp, 1'b0);
      chk1("rst_d_resp", d_resp, 1'b0);
      tick();
      rst = 1'b0;

      // single I read
      i_read = 1; i_address = 32'h0000_1000;
      neg(); chk1("i1_idle_rd", pmem_read, 1'b0); tick();
      neg(); chk1("i1_rd", pmem_read, 1'b1);
      chka("i1_addr", pmem_address, 32'h1000); tick();
      neg(); tick();
      neg(); tick();
      pmem_resp = 1; pmem_rdata = {32{8'hAA}};
      neg(); chk1("i1_resp", i_resp, 1'b1);
      chkw("i1_rdata", i_rdata, {32{8'hAA}});
      chk1("i1_d_resp", d_resp, 1'b0); tick();
      i_read = 0; pmem_resp = 0; pmem_rdata = '0;
      neg(); chk1("i1_rd_drop", pmem_read, 1'b0);
      chk1("i1_resp_once", i_resp, 1'b0); tick();

      // D write-back
      d_write = 1; d_address = 32'h2000; d_wdata = {32{8'h55}};
      neg(); tick();
      neg(); chk1("dw_wr", pmem_write, 1'b1);
      chk1("dw_rd", pmem_read, 1'b0);
      chkw("dw_wdata", pmem_wdata, {32{8'h55}});
      chka("dw_addr", pmem_address, 32'h2000); tick();
      neg(); tick();
      pmem_resp = 1;
      neg(); chk1("dw_resp", d_resp, 1'b1);
      chk1("dw_i_resp", i_resp, 1'b0); tick();
      d_write = 0; pmem_resp = 0;
      neg(); tick();

      // simultaneous after reset, then alternating tie-break
      rst = 1; neg(); tick();
      rst = 0;
      i_read = 1; i_address = 32'h3000;
      d_read = 1; d_address = 32'h4000;
      neg(); tick();
      neg(); chka("tie1_addr_i", pmem_address, 32'h3000);
      chk1("tie1_rd", pmem_read, 1'b1); tick();
      pmem_resp = 1;
      neg(); chk1("tie1_i_resp", i_resp, 1'b1);
      chk1("tie1_d_wait", d_resp, 1'b0); tick();
      i_read = 0; pmem_resp = 0;
      neg(); tick();
      neg(); chka("tie1_addr_d", pmem_address, 32'h4000); tick();
      pmem_resp = 1;
      neg(); chk1("tie1_d_resp", d_resp, 1'b1); tick();
      pmem_resp = 0;
      i_read = 1; i_address = 32'h3100; d_address = 32'h4100;
      neg(); tick();
      neg(); chka("tie2_addr_d", pmem_address, 32'h4100); tick();
      pmem_resp = 1;
      neg(); tick();
      d_read = 0; pmem_resp = 0;
      neg(); tick();
      neg(); chka("tie2_addr_i", pmem_address, 32'h3100);
      chk1("tie2_rd", pmem_read, 1'b1); tick();
      pmem_resp = 1;
      neg(); tick();
      i_read = 0; pmem_resp = 0;
      neg(); tick();

      // requester address change after grant
      d_read = 1; d_address = 32'h5000;
      neg(); tick();
      d_address = 32'h6000;
      neg(); chka("hold_addr1", pmem_address, 32'h5000); tick();
      neg(); chka("hold_addr2", pmem_address, 32'h5000); tick();
      pmem_resp = 1;
      neg(); tick();
      d_read = 0; pmem_resp = 0;
      neg(); tick();

      // reset mid-transaction
      i_read = 1; i_address = 32'h7000;
      neg(); tick();
      neg(); tick();
      rst = 1;
      neg(); chk1("mid_no_resp", i_resp, 1'b0); tick();
      rst = 0; i_read = 0;
      neg(); chk1("mid_rd_drop", pmem_read, 1'b0); tick();
      pmem_resp = 1;
      neg(); chk1("late_i_resp", i_resp, 1'b0);
      chk1("late_d_resp", d_resp, 1'b0); tick();
      pmem_resp = 0;

      // timeout
      d_read = 1; d_address = 32'h8000;
      neg(); tick();
      for (int k = 1; k <= TMO; k++) begin
         neg(); chk1("tmo_early", err_timeout, 1'b0); tick();
      end
      neg(); chk1("tmo_set", err_timeout, 1'b1); tick();
      pmem_resp = 1;
      neg(); chk1("tmo_late_resp", d_resp, 1'b1); tick();
      d_read = 0; pmem_resp = 0;
      neg(); chk1("tmo_sticky", err_timeout, 1'b1); tick();
      rst = 1; neg(); tick();
      rst = 0;
      neg(); chk1("tmo_cleared", err_timeout, 1'b0); tick();

      // random traffic
      ev_i_done = 0; ev_d_done = 0;
      for (int c = 0; c < 4000; c++) begin
         if (rst) begin
            rst = 0;
         end else if ($urandom_range(0, 299) == 0) begin
            rst = 1;
            i_read = 0; d_read = 0; d_write = 0;
            ev_i_done = 0; ev_d_done = 0;
         end
         if (ev_i_done) begin i_read = 0; ev_i_done = 0; end
         if (ev_d_done) begin
            d_read = 0; d_write = 0; ev_d_done = 0;
         end
         if (!rst && !i_read && $urandom_range(0, 3) == 0) i_read = 1;
         if (!rst && !(d_read | d_write) && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 15))
               0: begin d_read = 1; d_write = 1; end
               1, 2, 3, 4, 5, 6, 7: d_read = 1;
               default: d_write = 1;
            endcase
         end
         if ($urandom_range(0, 2) == 0) i_address = $urandom;
         if ($urandom_range(0, 2) == 0) d_address = $urandom;
         if ($urandom_range(0, 2) == 0) d_wdata = rand256();
         pmem_resp = (m_owner != 0) ? ($urandom_range(0, 4) == 0)
                                    : ($urandom_range(0, 7) == 0);
         pmem_rdata = rand256();
         neg();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_pmem_arbiter.md
Name: cache_pmem_arbiter

Overview:
- Shares one physical-memory port between an instruction cache (read-only) and a data cache (read/write).
- Sits between the two caches' pmem_* sides and the single main-memory model/port.
- Grants one full cache-line transaction at a time, with round-robin fairness.
- Latches the winning request and forwards the line data and response back to the granted cache only.

Parameters:
- ADDR_W, 32, address width in bits.
- LINE_W, 256, cache line width in bits.
- TIMEOUT, 1024, cycles a granted transaction may wait for pmem_resp before the error flag sets; 0 disables the check.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line data to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line write-back request; held until d_resp.
- d_address  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache write-back data.
- d_rdata  out  LINE_W  line data to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_W  latched memory address.
- pmem_wdata  out  LINE_W  latched write data.
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp.
- pmem_resp  in  1  memory completion.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- State machine: IDLE, SERVE_I, SERVE_D.
- Reset: state=IDLE; last_grant=D (so I-cache wins the first tie); pmem_read, pmem_write, i_resp, d_resp, err_timeout all 0; pmem_address and pmem_wdata 0; wait counter 0.
- Reset mid-transaction: the transaction is abandoned with no resp to either cache, and the next state is IDLE.
- IDLE, only I-cache requesting (i_read=1): latch i_address and op=read, go to SERVE_I.
- IDLE, only D-cache requesting (d_read or d_write =1): latch d_address, d_wdata and op, go to SERVE_D.
- IDLE, both requesting: grant the requester that is not last_grant, then update last_grant.
- IDLE, no requests: stay in IDLE.
- d_read and d_write asserted together is a protocol violation; the arbiter treats it as a write.
- Grant latency: a request sampled in IDLE at edge N gives pmem_read/pmem_write=1 from cycle N+1.
- pmem_* outputs are driven from registers only; requester address/data changes after grant are ignored.
- pmem_read and pmem_write are never both 1.
- SERVE_x strobes: assert pmem_read or pmem_write per the latched op, held until pmem_resp.
- SERVE_x completion: in the cycle pmem_resp=1, x_resp=1 combinationally and x_rdata=pmem_rdata. Next state is IDLE and strobes drop at that edge.
- Turnaround: at least one IDLE cycle between transactions, so back-to-back throughput is one line per (memory latency + 1) cycles.
- i_rdata and d_rdata always carry pmem_rdata; only the resp of the granted side qualifies it.
- The non-granted cache never sees resp, and its request stays pending through the current transaction.
- Timeout counter: clears on grant and increments each SERVE cycle without pmem_resp. When it reaches TIMEOUT, err_timeout sets and stays set until rst; the transaction continues waiting.
- pmem_resp while in IDLE is ignored; no resp is generated.

Test Plan:
- Single I read: i_read=1, i_address=0x0000_1000, memory resp after 3 cycles with rdata=0xAA..AA -> pmem_read=1 from next cycle, pmem_address=0x1000; i_resp pulses once with i_rdata=0xAA..AA; d_resp stays 0.
- D write-back: d_write=1, d_address=0x2000, d_wdata=0x55..55 -> pmem_write=1, pmem_wdata=0x55..55, pmem_read=0 throughout; d_resp pulses once.
- Simultaneous after reset: i_read and d_read both at 0x3000/0x4000 -> I served first, then D. Both held again -> the next grant alternates (D then I).
- Address change after grant: d_address changes 0x5000->0x6000 while in SERVE_D -> pmem_address stays 0x5000.
- Reset mid-transaction: rst during SERVE_I before pmem_resp -> next cycle IDLE, pmem_read=0, no i_resp; a late pmem_resp produces no resp.
- Timeout with TIMEOUT=8: pmem_resp withheld -> err_timeout=1 after 8 SERVE cycles; a later pmem_resp still completes with resp, and err_timeout remains 1 until rst.
